// File: rtl/dm_cache_ctrl_param_pkg.sv
// Shared definitions for the direct-mapped write-back cache controller.
// Line geometry stays on the module parameters; only fixed constants live here.
package cache_definition;
   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      COMPARE,
      WRITE_BACK,
      ALLOCATE,
      FLUSH_SCAN,
      FLUSH_WB
   } state_t;
endpackage

// File: rtl/dm_cache_store_param.sv
// Tag/valid/dirty/data arrays for the direct-mapped cache.
// Reads are asynchronous; a single write port updates a whole line and marks it valid.
module dm_cache_store_param #(
   parameter int INDEX_W = 10,
   parameter int TAG_W   = 6,
   parameter int LINE_W  = 128
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] idx,
   output logic [TAG_W-1:0]   rd_tag,
   output logic               rd_valid,
   output logic               rd_dirty,
   output logic [LINE_W-1:0]  rd_data,
   input  logic               we,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic               wr_dirty,
   input  logic [LINE_W-1:0]  wr_data
);
   localparam int DEPTH = 1 << INDEX_W;

   logic [TAG_W-1:0]  tag_mem  [DEPTH];
   logic [LINE_W-1:0] data_mem [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [DEPTH-1:0]  dirty_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (we) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= wr_dirty;
      end
   end

   // Payload arrays carry no reset; valid_q guards their contents.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_mem[idx]  <= wr_tag;
         data_mem[idx] <= wr_data;
      end
   end

   assign rd_tag   = tag_mem[idx];
   assign rd_data  = data_mem[idx];
   assign rd_valid = valid_q[idx];
   assign rd_dirty = dirty_q[idx];
endmodule

// File: rtl/dm_cache_ctrl_param.sv
// Direct-mapped write-back, write-allocate cache controller with whole-cache flush.
// Define DM_CACHE_STATS_EN to add hit/miss/write-back counters.
module dm_cache_ctrl_param
   import cache_definition::*;
#(
   parameter int ADDR_W  = 20,
   parameter int INDEX_W = 10,
   parameter int WORDS   = 4,
   localparam int OFF_W  = 2 + $clog2(WORDS),
   localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W,
   localparam int LINE_W = WORD_W * WORDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_valid,
   input  logic              cpu_rw,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [3:0]        cpu_be,
   output logic              cpu_ready,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   input  logic              flush_req,
   output logic              flush_done,
   output logic              mem_valid,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready
`ifdef DM_CACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt,
   output logic [31:0]       wb_cnt
`endif
);
   state_t              state;
   logic                req_pend, req_rw;
   logic [ADDR_W-1:0]   req_addr;
   logic [31:0]         req_wdata;
   logic [3:0]          req_be;
   logic [INDEX_W-1:0]  fcnt;

   logic [ADDR_W-1:0]   lk_addr;
   logic [TAG_W-1:0]    lk_tag;
   logic [INDEX_W-1:0]  lk_idx;
   logic [OFF_W-3:0]    lk_word;
   logic                act, act_rw, hit, mem_done, flushing;
   logic [31:0]         act_wd, old_word, merged;
   logic [3:0]          act_be;
   logic [INDEX_W-1:0]  st_idx;
   logic [TAG_W-1:0]    rd_tag, wr_tag;
   logic                rd_valid, rd_dirty, we, wr_dirty;
   logic [LINE_W-1:0]   rd_data, wr_data;
   logic                unused_bits;

   // A pending miss replays through the lookup path from the captured copy.
   assign lk_addr     = req_pend ? req_addr  : cpu_addr;
   assign act_rw      = req_pend ? req_rw    : cpu_rw;
   assign act_wd      = req_pend ? req_wdata : cpu_wdata;
   assign act_be      = req_pend ? req_be    : cpu_be;
   assign lk_tag      = lk_addr[ADDR_W-1 -: TAG_W];
   assign lk_idx      = lk_addr[OFF_W +: INDEX_W];
   assign lk_word     = lk_addr[OFF_W-1:2];
   assign unused_bits = ^lk_addr[1:0];

   assign flushing  = (state == FLUSH_SCAN) || (state == FLUSH_WB);
   assign st_idx    = flushing ? fcnt : lk_idx;
   assign act       = (state == COMPARE) && (req_pend || cpu_valid);
   assign hit       = rd_valid && (rd_tag == lk_tag);
   assign mem_done  = mem_valid && mem_ready;
   assign cpu_stall = !((state == COMPARE) && !req_pend);

   always_comb begin
      int wbase;
      wbase    = int'(lk_word) * WORD_W;
      old_word = rd_data[wbase +: WORD_W];
      for (int b = 0; b < 4; b++)
         merged[8*b +: 8] = act_be[b] ? act_wd[8*b +: 8] : old_word[8*b +: 8];
      we       = 1'b0;
      wr_tag   = rd_tag;
      wr_dirty = rd_dirty;
      wr_data  = rd_data;
      if (rst) begin
         if (act && hit && act_rw) begin
            we                       = 1'b1;
            wr_dirty                 = 1'b1;
            wr_data[wbase +: WORD_W] = merged;
         end else if (state == ALLOCATE && mem_done) begin
            we       = 1'b1;
            wr_tag   = lk_tag;
            wr_dirty = 1'b0;
            wr_data  = mem_rdata;
         end else if (state == FLUSH_WB && mem_done) begin
            we       = 1'b1;
            wr_dirty = 1'b0;
         end
      end
   end

   dm_cache_store_param #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .LINE_W  (LINE_W)
   ) u_store (
      .clk      (clk),
      .rst      (rst),
      .idx      (st_idx),
      .rd_tag   (rd_tag),
      .rd_valid (rd_valid),
      .rd_dirty (rd_dirty),
      .rd_data  (rd_data),
      .we       (we),
      .wr_tag   (wr_tag),
      .wr_dirty (wr_dirty),
      .wr_data  (wr_data)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= COMPARE;
         req_pend   <= 1'b0;
         req_rw     <= 1'b0;
         req_addr   <= '0;
         req_wdata  <= '0;
         req_be     <= '0;
         fcnt       <= '0;
         cpu_ready  <= 1'b0;
         cpu_rdata  <= '0;
         flush_done <= 1'b0;
         mem_valid  <= 1'b0;
         mem_rw     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         cpu_ready  <= 1'b0;
         flush_done <= 1'b0;
         case (state)
            COMPARE: begin
               if (act) begin
                  req_rw    <= act_rw;
                  req_addr  <= lk_addr;
                  req_wdata <= act_wd;
                  req_be    <= act_be;
                  if (hit) begin
                     req_pend  <= 1'b0;
                     cpu_ready <= 1'b1;
                     cpu_rdata <= act_rw ? merged : old_word;
                  end else begin
                     req_pend  <= 1'b1;
                     mem_valid <= 1'b1;
                     if (rd_valid && rd_dirty) begin
                        state     <= WRITE_BACK;
                        mem_rw    <= 1'b1;
                        mem_addr  <= {rd_tag, lk_idx, {OFF_W{1'b0}}};
                        mem_wdata <= rd_data;
                     end else begin
                        state    <= ALLOCATE;
                        mem_rw   <= 1'b0;
                        mem_addr <= {lk_tag, lk_idx, {OFF_W{1'b0}}};
                     end
                  end
               end else if (flush_req) begin
                  state <= FLUSH_SCAN;
                  fcnt  <= '0;
               end
            end
            WRITE_BACK: begin
               if (mem_done) begin
                  mem_valid <= 1'b0;
                  state     <= ALLOCATE;
               end
            end
            ALLOCATE: begin
               // Entered from WRITE_BACK with mem_valid low: issue the fill one cycle later.
               if (!mem_valid) begin
                  mem_valid <= 1'b1;
                  mem_rw    <= 1'b0;
                  mem_addr  <= {lk_tag, lk_idx, {OFF_W{1'b0}}};
               end else if (mem_ready) begin
                  mem_valid <= 1'b0;
                  state     <= COMPARE;
               end
            end
            FLUSH_SCAN: begin
               if (rd_valid && rd_dirty) begin
                  state     <= FLUSH_WB;
                  mem_valid <= 1'b1;
                  mem_rw    <= 1'b1;
                  mem_addr  <= {rd_tag, fcnt, {OFF_W{1'b0}}};
                  mem_wdata <= rd_data;
               end else if (&fcnt) begin
                  flush_done <= 1'b1;
                  fcnt       <= '0;
                  state      <= COMPARE;
               end else begin
                  fcnt <= fcnt + 1'b1;
               end
            end
            FLUSH_WB: begin
               if (mem_done) begin
                  mem_valid <= 1'b0;
                  fcnt      <= fcnt + 1'b1;
                  if (&fcnt) begin
                     flush_done <= 1'b1;
                     state      <= COMPARE;
                  end else begin
                     state <= FLUSH_SCAN;
                  end
               end
            end
            default: state <= COMPARE;
         endcase
      end
   end

`ifdef DM_CACHE_STATS_EN
   // Post-fill replays count as hits; flush write-backs count as write-backs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         wb_cnt   <= '0;
      end else begin
         if (act && hit)
            hit_cnt <= hit_cnt + 1'b1;
         if (act && !hit)
            miss_cnt <= miss_cnt + 1'b1;
         if (mem_done && (state == WRITE_BACK || state == FLUSH_WB))
            wb_cnt <= wb_cnt + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_dm_cache_ctrl_param.sv
// Directed bench for dm_cache_ctrl_param: vector table plus flush and reset sequences.
// Compile with DM_CACHE_STATS_EN to also check the statistics counters.
module tb_dm_cache_ctrl_param;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         cpu_valid = 1'b0, cpu_rw = 1'b0;
   logic [19:0]  cpu_addr = '0;
   logic [31:0]  cpu_wdata = '0;
   logic [3:0]   cpu_be = '0;
   logic         cpu_ready, cpu_stall, flush_done, mem_valid, mem_rw;
   logic [31:0]  cpu_rdata;
   logic         flush_req = 1'b0;
   logic [19:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata = '0;
   logic         mem_ready = 1'b0;
`ifdef DM_CACHE_STATS_EN
   logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

   int passed = 0, total = 0;
   bit hold_mem = 1'b0, late_pulse = 1'b0;

   typedef struct {
      logic         rw;
      logic [19:0]  addr;
      logic [127:0] data;
   } txn_t;
   txn_t log_q[$];

   typedef struct {
      logic        rw;
      logic [19:0] addr;
      logic [31:0] wd;
      logic [3:0]  be;
      logic        chk_rd;
      logic [31:0] rd;
      logic        hit;
   } vec_t;
   vec_t v[10];

   always #5 clk = ~clk;

   dm_cache_ctrl_param #(.ADDR_W(20), .INDEX_W(10), .WORDS(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_valid(cpu_valid), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .flush_req(flush_req), .flush_done(flush_done),
      .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef DM_CACHE_STATS_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
   );

   function automatic logic [127:0] mem_line(input logic [19:0] a);
      case (a)
         20'h00010: return {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'hDEADBEEF};
         20'h04010: return {32'h44440003, 32'h44440002, 32'h44440001, 32'h44440000};
         default:   return {4{12'h000, a}};
      endcase
   endfunction

   // Memory model: answers each request after three low cycles, logs every transaction.
   initial begin
      int wait_cnt = 0;
      forever begin
         @(negedge clk);
         if (hold_mem) begin
            mem_ready = late_pulse;
            wait_cnt  = 0;
         end else if (mem_ready) begin
            mem_ready = 1'b0;
         end else if (mem_valid) begin
            if (wait_cnt < 2) wait_cnt++;
            else begin
               wait_cnt = 0;
               mem_ready = 1'b1;
               log_q.push_back('{mem_rw, mem_addr, mem_wdata});
               if (!mem_rw) mem_rdata = mem_line(mem_addr);
            end
         end else wait_cnt = 0;
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else passed++;
   endtask

   task automatic access(input vec_t t, output logic [31:0] rd, output int lat, output bit ok);
      int n = 0;
      ok = 1'b0; lat = 0; rd = '0;
      @(negedge clk);
      while (cpu_stall && n < 100) begin @(negedge clk); n++; end
      cpu_valid = 1'b1; cpu_rw = t.rw; cpu_addr = t.addr; cpu_wdata = t.wd; cpu_be = t.be;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         cpu_valid = 1'b0;
         if (cpu_ready) begin rd = cpu_rdata; lat = k; ok = 1'b1; break; end
      end
   endtask

   task automatic run_vec(input int i);
      logic [31:0] rd; int lat; bit ok;
      access(v[i], rd, lat, ok);
      chk($sformatf("v%0d_done", i), ok, 1'b1);
      chk($sformatf("v%0d_hit", i), lat == 1, v[i].hit);
      if (v[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, v[i].rd);
   endtask

   task automatic run_flush(output int n, output bit rd_seen, output logic [31:0] rd);
      n = 0; rd_seen = 1'b0; rd = '0;
      flush_req = 1'b1;
      while (n < 3000) begin
         @(negedge clk); n++;
         cpu_valid = 1'b0;
         if (cpu_ready) begin rd_seen = 1'b1; rd = cpu_rdata; end
         if (n == 10) chk("flush_stall", cpu_stall, 1'b1);
         if (flush_done) break;
      end
      flush_req = 1'b0;
      chk("flush_done_seen", flush_done, 1'b1);
   endtask

   initial begin
      int base, n; bit seen; logic [31:0] rd;
      v[0] = '{1'b0, 20'h00010, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0};
      v[1] = '{1'b1, 20'h00014, 32'h00001234, 4'h3, 1'b0, 32'h0,        1'b1};
      v[2] = '{1'b0, 20'h00014, 32'h0,        4'h0, 1'b1, 32'hDEAD1234, 1'b1};
      v[3] = '{1'b0, 20'h04010, 32'h0,        4'h0, 1'b1, 32'h44440000, 1'b0};
      v[4] = '{1'b0, 20'h0401C, 32'h0,        4'h0, 1'b1, 32'h44440003, 1'b1};
      v[5] = '{1'b1, 20'h04018, 32'hABCD0000, 4'hC, 1'b0, 32'h0,        1'b1};
      v[6] = '{1'b0, 20'h04018, 32'h0,        4'h0, 1'b1, 32'hABCD0002, 1'b1};
      v[7] = '{1'b0, 20'h00018, 32'h0,        4'h0, 1'b1, 32'h22222222, 1'b0};
      v[8] = '{1'b1, 20'h00010, 32'h000000FF, 4'h1, 1'b0, 32'h0,        1'b1};
      v[9] = '{1'b0, 20'h00010, 32'h0,        4'h0, 1'b1, 32'hDEADBEFF, 1'b1};

      repeat (3) @(negedge clk);
      chk("rst_cpu_ready", cpu_ready, 1'b0);
      chk("rst_cpu_stall", cpu_stall, 1'b0);
      chk("rst_flush_done", flush_done, 1'b0);
      chk("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_mem_rw", mem_rw, 1'b0);
      chk("rst_cpu_rdata", cpu_rdata, 32'h0);
      rst = 1'b1;

      base = log_q.size();
      for (int i = 0; i < 4; i++) run_vec(i);
      chk("log_cnt", log_q.size() - base, 3);
      if (log_q.size() - base == 3) begin
         chk("log0", {log_q[base].rw, log_q[base].addr}, {1'b0, 20'h00010});
         chk("log1", {log_q[base+1].rw, log_q[base+1].addr}, {1'b1, 20'h00010});
         chk("log1_data", log_q[base+1].data,
             {32'h33333333, 32'h22222222, 32'hDEAD1234, 32'hDEADBEEF});
         chk("log2", {log_q[base+2].rw, log_q[base+2].addr}, {1'b0, 20'h04010});
      end
`ifdef DM_CACHE_STATS_EN
      chk("hit_cnt", hit_cnt, 32'd4);
      chk("miss_cnt", miss_cnt, 32'd2);
      chk("wb_cnt", wb_cnt, 32'd1);
`endif
      for (int i = 4; i < 10; i++) run_vec(i);

      // Flush with exactly one dirty line (index 1).
      base = log_q.size();
      run_flush(n, seen, rd);
      chk("flush1_wb_cnt", log_q.size() - base, 1);
      if (log_q.size() - base == 1) begin
         chk("flush1_wb", {log_q[base].rw, log_q[base].addr}, {1'b1, 20'h00010});
         chk("flush1_data", log_q[base].data,
             {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'hDEADBEFF});
      end
      chk("flush1_len_ok", (n >= 1026) && (n <= 1045), 1'b1);

      // CPU request in the same cycle as flush_req is served first; clean flush takes 1024 scans.
      base = log_q.size();
      @(negedge clk);
      cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 20'h00010;
      run_flush(n, seen, rd);
      chk("flush2_cpu_first", seen, 1'b1);
      chk("flush2_rdata", rd, 32'hDEADBEFF);
      chk("flush2_len", n, 1026);
      chk("flush2_no_wb", log_q.size() - base, 0);

      // Reset during an outstanding fill, then a stray mem_ready.
      hold_mem = 1'b1;
      @(negedge clk);
      cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 20'h08010;
      @(negedge clk);
      cpu_valid = 1'b0;
      chk("alloc_req", {mem_valid, mem_rw, mem_addr}, {1'b1, 1'b0, 20'h08010});
      chk("alloc_stall", cpu_stall, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_mem_valid", mem_valid, 1'b0);
      chk("mid_rst_stall", cpu_stall, 1'b0);
      chk("mid_rst_ready", {cpu_ready, flush_done, mem_rw}, 3'b000);
      rst = 1'b1;
      late_pulse = 1'b1;
      repeat (2) @(negedge clk);
      late_pulse = 1'b0;
      repeat (2) @(negedge clk);
      chk("late_ready_ignored", {mem_valid, cpu_stall, cpu_ready}, 3'b000);
      hold_mem = 1'b0;
`ifdef DM_CACHE_STATS_EN
      chk("rst_hit_cnt", hit_cnt, 32'd0);
`endif
      v[0] = '{1'b0, 20'h08010, 32'h0, 4'h0, 1'b1, 32'h00008010, 1'b0};
      run_vec(0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/dm_cache_ctrl_param.md
DM_CACHE_CTRL_PARAM -- requirements
Module: dm_cache_ctrl_param

Interface
REQ-001 SHALL take parameter ADDR_W, default 20, byte-address width.
REQ-002 SHALL take parameter INDEX_W, default 10, line-index width.
REQ-003 SHALL take parameter WORDS, default 4, 32-bit words per line (power of 2, >=2).
REQ-004 SHALL derive OFF_W=2+log2(WORDS), TAG_W=ADDR_W-INDEX_W-OFF_W, LINE_W=32*WORDS.
REQ-005 SHALL use one clock clk; reset rst is synchronous and active-low.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst  in  1  synchronous active-low reset.
REQ-008 cpu_valid  in  1  CPU request present.
REQ-009 cpu_rw  in  1  1=write, 0=read.
REQ-010 cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
REQ-011 cpu_wdata  in  32  write word.
REQ-012 cpu_be  in  4  byte enables for writes.
REQ-013 cpu_ready  out  1  one-cycle completion pulse.
REQ-014 cpu_rdata  out  32  read word, valid with cpu_ready.
REQ-015 cpu_stall  out  1  request not accepted this cycle.
REQ-016 flush_req  in  1  level request to write back all dirty lines.
REQ-017 flush_done  out  1  one-cycle pulse at flush end.
REQ-018 mem_valid/mem_rw/mem_addr(ADDR_W)/mem_wdata(LINE_W)  out  memory request, line-aligned.
REQ-019 mem_rdata  in  LINE_W  fill data; mem_ready  in  1  memory completion.

Function
REQ-020 States: COMPARE, WRITE_BACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB.
REQ-021 Request captured at edge when cpu_valid&&!cpu_stall; cpu_stall=1 in every state except COMPARE-without-pending-miss.
REQ-022 Hit (valid && tag match): cpu_ready asserted in the cycle after capture; reads return word addr[OFF_W-1:2]; writes merge bytes per cpu_be, set dirty, also pulse cpu_ready.
REQ-023 Miss, victim clean or invalid: ALLOCATE, mem_valid=1, mem_rw=0, mem_addr={tag,index,OFF_W'0}.
REQ-024 Miss, victim valid&dirty: WRITE_BACK, mem_rw=1, mem_addr={victim tag,index,0}, mem_wdata=victim line; on mem_ready -> ALLOCATE.
REQ-025 ALLOCATE on mem_ready: write line, valid=1, dirty=0, tag updated -> COMPARE; captured request then completes as a hit next cycle.
REQ-026 mem_valid and all mem_* outputs held stable until mem_ready; mem_valid low for >=1 cycle between transactions.
REQ-027 flush_req accepted only in COMPARE with no pending request; cpu_valid in same cycle wins, flush waits.
REQ-028 FLUSH_SCAN visits index 0..2^INDEX_W-1, one per cycle; dirty line -> FLUSH_WB (write back, clear dirty, resume next index).
REQ-029 After last index flush_done pulses one cycle, back to COMPARE; valid bits unchanged.
REQ-030 Index counter wraps only at flush end; no line skipped or visited twice.

Reset
REQ-031 rst=0 at edge: state COMPARE, all valid and dirty bits 0, no pending request, flush counter 0.
REQ-032 Outputs during/after reset: cpu_ready=0, cpu_stall=0, flush_done=0, mem_valid=0, mem_rw=0, cpu_rdata=0.
REQ-033 Reset mid-transaction abandons it; mem_valid low the cycle after reset edge; late mem_ready ignored.

Configuration
REQ-034 Macro DM_CACHE_STATS_EN adds outputs hit_cnt, miss_cnt, wb_cnt (32 bits each, wrap, reset to 0, flush write-backs counted in wb_cnt).
REQ-035 Without DM_CACHE_STATS_EN these ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-036 Package cache_definition SHALL hold the state enum and a WORD_W=32 constant; widths stay module parameters.
REQ-037 Tag/valid/dirty/data arrays SHALL live in sub-module dm_cache_store_param (async read, sync write, parametrised).

Verification
REQ-038 Reset, read 0x00010 -> ALLOCATE addr 0x00010; mem_rdata word1=0xDEADBEEF, mem_ready -> cpu_ready, cpu_rdata=0xDEADBEEF.
REQ-039 Then write 0x00014 be=4'b0011 data 0x00001234 -> cpu_ready next cycle; read 0x00014 returns 0xDEAD1234.
REQ-040 Then read 0x04010 -> WRITE_BACK addr 0x00010 with word1 0xDEAD1234, then ALLOCATE addr 0x04010.
REQ-041 One dirty line, flush_req=1 -> exactly one mem_rw=1 transaction, flush_done after 1024 scanned indices.
REQ-042 rst=0 during ALLOCATE before mem_ready -> mem_valid=0 next cycle; following read of same address misses.
REQ-043 With DM_CACHE_STATS_EN, REQ-038..040 sequence -> hit_cnt=4, miss_cnt=2, wb_cnt=1.
